// File: rtl/uart_cmd_link.sv
// ============================================================================
// Module      : uart_cmd_link
// Description : Host-side UART link layer. Packs three received bytes into a
//               24-bit command with a ready/clear handshake, and serialises
//               single-byte responses through a one-deep pending buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_cmd_link #(
    parameter int TIMEOUT_CYCLES = 26040
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_rdy,
    input  logic [7:0]  rx_data,
    output logic [23:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    input  logic [7:0]  resp_data,
    output logic        resp_sent,
    output logic        trmt,
    output logic [7:0]  tx_data,
    input  logic        tx_done,
    output logic        frame_err,
    output logic        cmd_ovr,
    output logic        tx_ovr
);

    localparam int c_cnt_w = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_to_last = c_cnt_w'(TIMEOUT_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

    localparam logic [1:0] c_rx_b1 = 2'd0;
    localparam logic [1:0] c_rx_b2 = 2'd1;
    localparam logic [1:0] c_rx_b3 = 2'd2;

    localparam logic [0:0] c_tx_idle = 1'b0;
    localparam logic [0:0] c_tx_busy = 1'b1;

    logic [1:0]         r_rx_state;
    logic [15:0]        r_shadow;
    logic [c_cnt_w-1:0] r_to_cnt;
    logic [23:0]        r_cmd;
    logic               r_cmd_rdy;
    logic               r_cmd_ovr;
    logic               r_frame_err;

    logic [0:0]         r_tx_state;
    logic [7:0]         r_tx_data;
    logic               r_trmt;
    logic               r_resp_sent;
    logic               r_pend_vld;
    logic [7:0]         r_pend_data;
    logic               r_tx_ovr;

    logic               w_frame_done;
    logic               w_accept;

    assign w_frame_done = rx_rdy && (r_rx_state == c_rx_b3);
    // A clear in the completing cycle frees the slot, so the new frame wins.
    assign w_accept     = w_frame_done && (!r_cmd_rdy || clr_cmd_rdy);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_state  <= c_rx_b1;
            r_shadow    <= 16'h0000;
            r_to_cnt    <= '0;
            r_cmd       <= 24'h000000;
            r_cmd_rdy   <= 1'b0;
            r_cmd_ovr   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;

            if (rx_rdy) begin
                r_to_cnt <= '0;
                case (r_rx_state)
                    c_rx_b1: begin
                        r_shadow[15:8] <= rx_data;
                        r_rx_state     <= c_rx_b2;
                    end
                    c_rx_b2: begin
                        r_shadow[7:0]  <= rx_data;
                        r_rx_state     <= c_rx_b3;
                    end
                    default: r_rx_state <= c_rx_b1;
                endcase
            end else if (r_rx_state == c_rx_b1) begin
                r_to_cnt <= '0;
            end else if (r_to_cnt == c_to_last) begin
                r_to_cnt    <= '0;
                r_rx_state  <= c_rx_b1;
                r_frame_err <= 1'b1;
            end else begin
                r_to_cnt <= r_to_cnt + c_cnt_one;
            end

            if (w_accept) begin
                r_cmd     <= {r_shadow, rx_data};
                r_cmd_rdy <= 1'b1;
            end else if (clr_cmd_rdy) begin
                r_cmd_rdy <= 1'b0;
            end

            if (w_frame_done && !w_accept) begin
                r_cmd_ovr <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state  <= c_tx_idle;
            r_tx_data   <= 8'h00;
            r_trmt      <= 1'b0;
            r_resp_sent <= 1'b0;
            r_pend_vld  <= 1'b0;
            r_pend_data <= 8'h00;
            r_tx_ovr    <= 1'b0;
        end else begin
            r_trmt      <= 1'b0;
            r_resp_sent <= 1'b0;

            if (r_tx_state == c_tx_idle) begin
                if (send_resp) begin
                    r_tx_data  <= resp_data;
                    r_trmt     <= 1'b1;
                    r_tx_state <= c_tx_busy;
                end
            end else if (tx_done) begin
                r_resp_sent <= 1'b1;
                if (r_pend_vld) begin
                    r_tx_data <= r_pend_data;
                    r_trmt    <= 1'b1;
                    if (send_resp) begin
                        r_pend_data <= resp_data;
                    end else begin
                        r_pend_vld  <= 1'b0;
                    end
                end else if (send_resp) begin
                    // Transmitter frees up this cycle: launch directly instead of parking.
                    r_tx_data <= resp_data;
                    r_trmt    <= 1'b1;
                end else begin
                    r_tx_state <= c_tx_idle;
                end
            end else if (send_resp) begin
                if (r_pend_vld) begin
                    r_tx_ovr <= 1'b1;
                end else begin
                    r_pend_data <= resp_data;
                    r_pend_vld  <= 1'b1;
                end
            end
        end
    end

    assign cmd       = r_cmd;
    assign cmd_rdy   = r_cmd_rdy;
    assign cmd_ovr   = r_cmd_ovr;
    assign frame_err = r_frame_err;
    assign tx_data   = r_tx_data;
    assign trmt      = r_trmt;
    assign resp_sent = r_resp_sent;
    assign tx_ovr    = r_tx_ovr;

endmodule

`default_nettype wire

// File: tb/tb_uart_cmd_link.sv
// ============================================================================
// Module      : tb_uart_cmd_link
// Description : Self-checking bench for uart_cmd_link: directed scenarios plus
//               randomized traffic against a queue-based behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_cmd_link;

    localparam int T = 150;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_rdy = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        clr_cmd_rdy = 1'b0;
    logic        send_resp = 1'b0;
    logic [7:0]  resp_data = 8'h00;
    logic        tx_done = 1'b0;
    logic [23:0] cmd;
    logic        cmd_rdy;
    logic        resp_sent;
    logic        trmt;
    logic [7:0]  tx_data;
    logic        frame_err;
    logic        cmd_ovr;
    logic        tx_ovr;

    int n_checks = 0;
    int n_err    = 0;

    uart_cmd_link #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .rx_rdy(rx_rdy), .rx_data(rx_data),
        .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
        .send_resp(send_resp), .resp_data(resp_data), .resp_sent(resp_sent),
        .trmt(trmt), .tx_data(tx_data), .tx_done(tx_done),
        .frame_err(frame_err), .cmd_ovr(cmd_ovr), .tx_ovr(tx_ovr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: frame as a byte array with an index, responses as a
    // queue of at most one waiting byte behind the one in flight.
    logic [7:0]  m_bytes [3];
    int          m_idx = 0;
    int          m_idle = 0;
    logic [23:0] m_cmd = '0;
    logic        m_cmd_rdy = 0, m_cmd_ovr = 0, m_frame_err = 0;
    logic        m_busy = 0, m_trmt = 0, m_resp_sent = 0, m_tx_ovr = 0;
    logic [7:0]  m_tx_data = '0;
    logic [7:0]  m_pq [$];

    task automatic model_step();
        m_trmt = 0; m_resp_sent = 0; m_frame_err = 0;
        if (rst) begin
            m_idx = 0; m_idle = 0; m_cmd = '0; m_cmd_rdy = 0; m_cmd_ovr = 0;
            m_busy = 0; m_tx_ovr = 0; m_tx_data = '0; m_pq.delete();
        end else begin
            if (rx_rdy) begin
                m_bytes[m_idx] = rx_data;
                m_idle = 0;
                if (m_idx == 2) begin
                    m_idx = 0;
                    if (!m_cmd_rdy || clr_cmd_rdy) begin
                        m_cmd = {m_bytes[0], m_bytes[1], m_bytes[2]};
                        m_cmd_rdy = 1;
                    end else begin
                        m_cmd_ovr = 1;
                    end
                end else begin
                    m_idx++;
                    if (clr_cmd_rdy) m_cmd_rdy = 0;
                end
            end else begin
                if (clr_cmd_rdy) m_cmd_rdy = 0;
                if (m_idx != 0) begin
                    m_idle++;
                    if (m_idle == T) begin
                        m_idx = 0; m_idle = 0; m_frame_err = 1;
                    end
                end
            end

            if (m_busy && tx_done) begin
                m_resp_sent = 1;
                if (m_pq.size() > 0) begin
                    m_tx_data = m_pq.pop_front();
                    m_trmt = 1;
                end else begin
                    m_busy = 0;
                end
            end
            if (send_resp) begin
                if (!m_busy) begin
                    m_tx_data = resp_data; m_trmt = 1; m_busy = 1;
                end else if (m_pq.size() == 0) begin
                    m_pq.push_back(resp_data);
                end else begin
                    m_tx_ovr = 1;
                end
            end
        end
    endtask

    always @(posedge clk) begin
        model_step();
        #1;
        check("cmd",       32'(cmd),       32'(m_cmd));
        check("cmd_rdy",   32'(cmd_rdy),   32'(m_cmd_rdy));
        check("cmd_ovr",   32'(cmd_ovr),   32'(m_cmd_ovr));
        check("frame_err", 32'(frame_err), 32'(m_frame_err));
        check("trmt",      32'(trmt),      32'(m_trmt));
        check("tx_data",   32'(tx_data),   32'(m_tx_data));
        check("resp_sent", 32'(resp_sent), 32'(m_resp_sent));
        check("tx_ovr",    32'(tx_ovr),    32'(m_tx_ovr));
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic with_clr);
        rx_rdy = 1; rx_data = b; clr_cmd_rdy = with_clr;
        @(negedge clk);
        rx_rdy = 0; clr_cmd_rdy = 0;
    endtask

    task automatic resp(input logic [7:0] b);
        send_resp = 1; resp_data = b;
        @(negedge clk);
        send_resp = 0;
    endtask

    task automatic done_pulse();
        tx_done = 1;
        @(negedge clk);
        tx_done = 0;
    endtask

    int quiet = 0;
    int fe_cnt;

    initial begin
        idle(2);
        rst = 0;
        check("reset_all", {8'h0, cmd}, 32'h0);
        check("reset_flags", {cmd_rdy, cmd_ovr, frame_err, trmt, resp_sent, tx_ovr}, 32'h0);

        // Plain frame with long gaps, then clear.
        send_byte(8'h02, 0); idle(100);
        send_byte(8'h05, 0); idle(100);
        send_byte(8'h10, 0);
        check("t1_cmd", 32'(cmd), 32'h020510);
        check("t1_rdy", 32'(cmd_rdy), 32'h1);
        clr_cmd_rdy = 1; @(negedge clk); clr_cmd_rdy = 0;
        check("t1_clr_rdy", 32'(cmd_rdy), 32'h0);
        check("t1_cmd_kept", 32'(cmd), 32'h020510);

        // Partial frame times out.
        send_byte(8'h09, 0);
        send_byte(8'h3F, 0);
        fe_cnt = 0;
        for (int i = 0; i < T + 2; i++) begin
            @(negedge clk);
            if (frame_err) fe_cnt++;
        end
        check("t2_frame_err_pulses", 32'(fe_cnt), 32'd1);
        check("t2_no_rdy", 32'(cmd_rdy), 32'h0);
        send_byte(8'h08, 0); send_byte(8'h01, 0); send_byte(8'hAB, 0);
        check("t2_cmd", 32'(cmd), 32'h0801AB);

        // Overrun while cmd_rdy is held, then accept with same-cycle clear.
        send_byte(8'h03, 0); send_byte(8'h00, 0); send_byte(8'h44, 0);
        check("t3_cmd_kept", 32'(cmd), 32'h0801AB);
        check("t3_cmd_ovr", 32'(cmd_ovr), 32'h1);
        send_byte(8'h03, 0); send_byte(8'h00, 0); send_byte(8'h44, 1);
        check("t3_cmd_new", 32'(cmd), 32'h030044);
        check("t3_rdy", 32'(cmd_rdy), 32'h1);
        clr_cmd_rdy = 1; @(negedge clk); clr_cmd_rdy = 0;

        // Bytes landing exactly on the expiry cycle are accepted.
        fe_cnt = 0;
        send_byte(8'h0A, 0); idle(T - 1);
        send_byte(8'h0B, 0); idle(T - 1);
        send_byte(8'h0C, 0);
        check("t4_edge_cmd", 32'(cmd), 32'h0A0B0C);
        clr_cmd_rdy = 1; @(negedge clk); clr_cmd_rdy = 0;

        // Single response.
        resp(8'hA5);
        check("t5_trmt", 32'(trmt), 32'h1);
        check("t5_tx_data", 32'(tx_data), 32'hA5);
        idle(200);
        done_pulse();
        check("t5_resp_sent", 32'(resp_sent), 32'h1);
        check("t5_no_trmt", 32'(trmt), 32'h0);

        // Back-to-back responses through the pending buffer, then a drop.
        resp(8'hA5); idle(3);
        resp(8'h7E); idle(3);
        done_pulse();
        check("t6_sent", 32'(resp_sent), 32'h1);
        check("t6_trmt", 32'(trmt), 32'h1);
        check("t6_tx_data", 32'(tx_data), 32'h7E);
        resp(8'h11);
        resp(8'h22);
        check("t6_tx_ovr", 32'(tx_ovr), 32'h1);
        idle(5); done_pulse();
        check("t6_next", 32'(tx_data), 32'h11);
        idle(5); done_pulse(); idle(2);
        check("t6_idle_trmt", 32'(trmt), 32'h0);

        // Reset mid-frame and mid-transmit.
        send_byte(8'h01, 0); send_byte(8'h02, 0);
        resp(8'h33); idle(2);
        rst = 1; @(negedge clk); rst = 0;
        check("t7_reset_cmd", {8'h0, cmd}, 32'h0);
        check("t7_reset_flags", {cmd_rdy, cmd_ovr, frame_err, trmt, resp_sent, tx_ovr, tx_data}, 32'h0);
        done_pulse();
        check("t7_late_done", 32'(resp_sent), 32'h0);
        send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h00, 0);
        check("t7_cmd", 32'(cmd), 32'h010200);

        // Randomized traffic.
        for (int i = 0; i < 8000; i++) begin
            if (quiet > 0) begin
                rx_rdy = 0; quiet--;
            end else if ($urandom_range(0, 299) == 0) begin
                rx_rdy = 0; quiet = T - 3 + int'($urandom_range(0, 6));
            end else begin
                rx_rdy = ($urandom_range(0, 3) == 0);
            end
            rx_data     = 8'($urandom);
            clr_cmd_rdy = ($urandom_range(0, 4) == 0);
            send_resp   = ($urandom_range(0, 5) == 0);
            resp_data   = 8'($urandom);
            tx_done     = ($urandom_range(0, 6) == 0);
            rst         = ($urandom_range(0, 1999) == 0);
            @(negedge clk);
        end
        rx_rdy = 0; clr_cmd_rdy = 0; send_resp = 0; tx_done = 0; rst = 0;
        idle(3);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_cmd_link.md
# uart_cmd_link

Host-side link layer between the UART byte engine and the DSO command processor. It assembles three received UART bytes into one 24-bit command and presents it with a `cmd_rdy`/`clr_cmd_rdy` handshake. In the other direction it accepts single-byte responses (`send_resp`/`resp_data`), serializes them onto the UART transmitter and returns `resp_sent` on completion. An inter-byte timeout resynchronises framing, and a one-deep response buffer absorbs back-to-back responses.

## Interface
- `TIMEOUT_CYCLES`, default 26040: idle clocks allowed between bytes of one frame before it is abandoned.
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-high.
- `rx_rdy` in 1: one-cycle pulse, new byte on `rx_data`.
- `rx_data` in 8: received byte.
- `cmd` out 24: assembled command; byte 1 → [23:16], byte 2 → [15:8], byte 3 → [7:0].
- `cmd_rdy` out 1: command valid; held until cleared.
- `clr_cmd_rdy` in 1: level from the command processor; clears `cmd_rdy`.
- `send_resp` in 1: one-cycle request to transmit `resp_data`.
- `resp_data` in 8: response byte; sampled only in the `send_resp` cycle.
- `resp_sent` out 1: one-cycle pulse when a response byte has fully transmitted.
- `trmt` out 1: one-cycle start pulse to the UART transmitter.
- `tx_data` out 8: byte to the transmitter; stable from `trmt` until `tx_done`.
- `tx_done` in 1: one-cycle pulse, transmitter finished the byte.
- `frame_err` out 1: one-cycle pulse when a partial frame times out.
- `cmd_ovr` out 1: sticky; a completed frame was discarded.
- `tx_ovr` out 1: sticky; a response was dropped.

## Operation
- Reset: all outputs 0, receive FSM in `RX_B1`, transmit FSM in `TX_IDLE`, pending buffer empty, timeout counter 0. The sticky flags clear only on reset.
- Receive FSM states: `RX_B1`, `RX_B2`, `RX_B3`.
  - `rx_rdy` in `RX_B1`: byte → shadow[23:16], go to `RX_B2`.
  - `rx_rdy` in `RX_B2`: byte → shadow[15:8], go to `RX_B3`.
  - `rx_rdy` in `RX_B3`: frame complete, go to `RX_B1`.
- Frame complete with `cmd_rdy`=0, or with `clr_cmd_rdy`=1 in the same cycle: `cmd` ← {shadow[23:8], rx_data} and `cmd_rdy` ← 1. Set wins over a simultaneous clear.
- Frame complete with `cmd_rdy`=1 and `clr_cmd_rdy`=0: frame discarded, `cmd` unchanged, `cmd_ovr` ← 1.
- `cmd` changes only on an accepted frame. It stays valid after `cmd_rdy` clears, because the processor reads `cmd` fields during later states.
- Timeout counter:
  - Cleared on every `rx_rdy` and while in `RX_B1`; increments otherwise.
  - Reaching `TIMEOUT_CYCLES`-1 in `RX_B2`/`RX_B3`: go to `RX_B1`, pulse `frame_err`, shadow is not used.
  - `rx_rdy` in the expiry cycle takes priority: the byte is accepted and there is no error.
- Transmit FSM states: `TX_IDLE`, `TX_BUSY`.
  - `TX_IDLE` + `send_resp`: `tx_data` ← `resp_data`, `trmt` pulse next cycle, go to `TX_BUSY`.
  - `TX_BUSY` + `send_resp`, buffer empty: store byte in pending buffer.
  - `TX_BUSY` + `send_resp`, buffer full: drop byte, `tx_ovr` ← 1.
  - `TX_BUSY` + `tx_done`: pulse `resp_sent`. If pending is valid, then `tx_data` ← pending, pulse `trmt`, stay in `TX_BUSY`, and pending becomes empty. Otherwise go to `TX_IDLE`.
  - `tx_done` and `send_resp` in the same cycle with the buffer full: the pending byte moves to `tx_data` and the new byte takes the buffer. No drop.
- `tx_done` in `TX_IDLE` is ignored.

## Timing
- All outputs are registered.
- `cmd`/`cmd_rdy` update on the clock edge after the 3rd `rx_rdy`, i.e. visible one cycle after the 3rd byte pulse.
- `cmd_rdy` falls on the edge after `clr_cmd_rdy`=1.
- `trmt` is high exactly one cycle, the cycle after `send_resp` (idle case) or the cycle after `tx_done` (pending case).
- `resp_sent` is high exactly one cycle, the cycle after `tx_done`.
- `frame_err` is high one cycle.
- Timeout fires exactly `TIMEOUT_CYCLES` clocks after the last accepted byte with no further `rx_rdy`.
- Reset mid-frame or mid-transmit: the next edge with `rst`=1 returns everything to reset values. A `tx_done` arriving after reset is ignored.
- Back-to-back `rx_rdy` on consecutive cycles is supported; each byte advances the FSM.

## Test plan
- Bytes 0x02, 0x05, 0x10 with 100-cycle gaps → `cmd`=0x020510 and `cmd_rdy`=1 one cycle after the 3rd pulse; `clr_cmd_rdy` → `cmd_rdy`=0 next cycle with `cmd` still 0x020510.
- Bytes 0x09, 0x3F then silence of `TIMEOUT_CYCLES` → one `frame_err` pulse, no `cmd_rdy`. Then 0x08, 0x01, 0xAB → `cmd`=0x0801AB.
- `cmd_rdy` held, new frame 0x030044 arrives → `cmd` stays the old value, `cmd_ovr`=1. Repeat with `clr_cmd_rdy`=1 on the 3rd-byte cycle → `cmd`=0x030044 and `cmd_rdy`=1.
- `send_resp` 0xA5 idle → `trmt` next cycle, `tx_data`=0xA5; `tx_done` 200 cycles later → `resp_sent` pulse, FSM in `TX_IDLE`.
- `send_resp` 0xA5, then `send_resp` 0x7E while busy → after the first `tx_done`: `resp_sent` and `trmt` together with `tx_data`=0x7E; a second `tx_done` → `resp_sent`, back to `TX_IDLE`. A third `send_resp` while the buffer is full → `tx_ovr`=1.
- Assert `rst` after byte 2 and mid-transmit → all outputs 0. Then a full frame 0x010200 → `cmd`=0x010200.
